pipeline_ctrl: RTL

Central sequencing controller for the 5-stage pipeline: it drives the enable/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, flushes on taken branches and selects EX-stage operand forwarding. It also stalls the whole pipeline through a variable-latency data-memory req/ack handshake, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_forward_unit.sv | 26 ++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and
// EX-stage operand forwarding selects.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forwarding select for one EX-stage source register.
// The younger EX/MEM result takes priority over MEM/WB.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_sel
);

  // Compare the source register against both in-flight destinations.
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencing controller: load-use stalls, branch flushes,
// operand forwarding, data-memory wait stalls and saturating perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             mem_memread_i,
  input  logic             mem_memwrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_regwrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_mem_err, w_mem_err_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_mem_access, w_mem_stall, w_load_use, w_req;
  logic [1:0]        w_fwd_a, w_fwd_b;

  assign w_mem_access = mem_memread_i | mem_memwrite_i;

  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (ex_rd_i == id_rs1_i)) ||
                       (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

  // Memory handshake FSM: a late ack stalls until ack or timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    w_mem_stall    = 1'b0;
    w_req          = 1'b0;
    case (r_state)
      RUN: begin
        w_req = w_mem_access;
        if (w_mem_access && !dmem_ack_i) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        w_req = 1'b1;
        if (dmem_ack_i) begin
          w_state_nxt = RUN;
        end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          w_mem_err_nxt = 1'b1;
          w_state_nxt   = RUN;
        end else begin
          w_mem_stall    = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Pipeline register controls; reset forces a fully flushed, frozen pipe.
  always_comb begin
    pc_en_o         = 1'b0;
    if_id_en_o      = 1'b0;
    id_ex_en_o      = 1'b0;
    ex_mem_en_o     = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst_i) begin
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (w_mem_stall) begin
      mem_wb_bubble_o = 1'b1;
    end else if (w_load_use) begin
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      if_id_flush_o = branch_taken_i;
    end
  end

  forward_unit u_fwd_a (
    .i_rs           (ex_rs1_i),
    .i_mem_rd       (mem_rd_i),
    .i_mem_regwrite (mem_regwrite_i),
    .i_wb_rd        (wb_rd_i),
    .i_wb_regwrite  (wb_regwrite_i),
    .o_sel          (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs           (ex_rs2_i),
    .i_mem_rd       (mem_rd_i),
    .i_mem_regwrite (mem_regwrite_i),
    .i_wb_rd        (wb_rd_i),
    .i_wb_regwrite  (wb_regwrite_i),
    .o_sel          (w_fwd_b)
  );

  assign dmem_req_o = rst_i ? 1'b0 : w_req;
  assign fwd_a_o    = rst_i ? FWD_RF : w_fwd_a;
  assign fwd_b_o    = rst_i ? FWD_RF : w_fwd_b;

  // State, wait counter, sticky error and saturating perf counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
      if (!pc_en_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (if_id_flush_o && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign mem_err_o   = r_mem_err;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
